// File: rtl/nand_ctrl_pkg.sv
// Shared definitions for the NAND flash controller: NAND opcodes, host register
// map, operation select codes and the sequencing FSM states.
package nand_ctrl_pkg;

  localparam logic [7:0] NAND_CMD_READ1  = 8'h00;
  localparam logic [7:0] NAND_CMD_READ2  = 8'h30;
  localparam logic [7:0] NAND_CMD_ERASE1 = 8'h60;
  localparam logic [7:0] NAND_CMD_ERASE2 = 8'hD0;
  localparam logic [7:0] NAND_CMD_PROG1  = 8'h80;
  localparam logic [7:0] NAND_CMD_PROG2  = 8'h10;
  localparam logic [7:0] NAND_CMD_STATUS = 8'h70;
  localparam logic [7:0] NAND_CMD_RESET  = 8'hFF;

  localparam logic [11:0] REG_COL1   = 12'hFF0;
  localparam logic [11:0] REG_COL2   = 12'hFF1;
  localparam logic [11:0] REG_ROW1   = 12'hFF2;
  localparam logic [11:0] REG_ROW2   = 12'hFF3;
  localparam logic [11:0] REG_ROW3   = 12'hFF4;
  localparam logic [11:0] REG_CMD    = 12'hFFA;
  localparam logic [11:0] REG_STATUS = 12'hFFB;

  localparam logic [3:0] OP_READ    = 4'h0;
  localparam logic [3:0] OP_ERASE   = 4'h6;
  localparam logic [3:0] OP_STATUS  = 4'h7;
  localparam logic [3:0] OP_PROGRAM = 4'h8;
  localparam logic [3:0] OP_RESET   = 4'hF;
  localparam logic [3:0] START_KEY  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD1,
    S_ADDR,
    S_DATA_WR,
    S_CMD2,
    S_BUSY,
    S_DATA_RD
  } state_t;

  function automatic logic isValidOp(input logic [3:0] op);
    return (op == OP_READ) || (op == OP_ERASE) || (op == OP_STATUS) ||
           (op == OP_PROGRAM) || (op == OP_RESET);
  endfunction

  function automatic logic [7:0] firstCmd(input logic [3:0] op);
    case (op)
      OP_RESET:   return NAND_CMD_RESET;
      OP_ERASE:   return NAND_CMD_ERASE1;
      OP_PROGRAM: return NAND_CMD_PROG1;
      OP_STATUS:  return NAND_CMD_STATUS;
      default:    return NAND_CMD_READ1;
    endcase
  endfunction

  function automatic logic [7:0] secondCmd(input logic [3:0] op);
    case (op)
      OP_ERASE:   return NAND_CMD_ERASE2;
      OP_PROGRAM: return NAND_CMD_PROG2;
      default:    return NAND_CMD_READ2;
    endcase
  endfunction

endpackage

// File: rtl/nand_page_buffer.sv
// Single-port page buffer with synchronous read; the port is shared between the
// host (while idle) and the sequencing FSM (while an operation runs).
module nand_page_buffer #(
  parameter int PAGE_WORDS = 1024,
  parameter int AW         = 10
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [15:0]   i_wdata,
  output logic [15:0]   o_rdata
);

  logic [15:0] r_mem [PAGE_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/nand_flash_controller.sv
// Host-bus to x16 asynchronous NAND bridge: register window, page buffer and the
// FSM that sequences reset, erase, program, read and status operations.
module nand_flash_controller
  import nand_ctrl_pkg::*;
#(
  parameter int PAGE_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic        WE,
  input  logic        OE,
  input  logic [11:0] ADDRESS,
  inout  wire  [15:0] DATA,
  output logic        RnB,
  output logic        CE_n,
  output logic        WE_n,
  output logic        RE_n,
  output logic        CLE_n,
  output logic        ALE_n,
  inout  wire  [15:0] data_n,
  input  logic        RnB_n
);

  localparam int          AW         = (PAGE_WORDS > 1) ? $clog2(PAGE_WORDS) : 1;
  localparam logic [11:0] PAGE_LIMIT = 12'(PAGE_WORDS);
  localparam logic [AW-1:0] LAST_WORD = AW'(PAGE_WORDS - 1);

  state_t        r_state, w_nextState;
  logic          r_phase;
  logic [2:0]    r_addrIdx;
  logic [AW-1:0] r_wordCnt;
  logic [1:0]    r_waitCnt;
  logic [3:0]    r_op;
  logic          r_rnb;
  logic [7:0]    r_col1, r_col2, r_row1, r_row2, r_row3;
  logic [15:0]   r_cmd;
  logic [7:0]    r_status;
  logic [11:0]   r_rdAddr;
  logic          r_rnbMeta, r_rnbSync;
  logic [15:0]   r_dataIn;

  logic          w_hostWr, w_start;
  logic          w_nandDrive;
  logic [15:0]   w_nandOut;
  logic [7:0]    w_addrByte;
  logic [15:0]   w_hostRdData;
  logic          w_bufWe;
  logic [AW-1:0] w_bufAddr;
  logic [15:0]   w_bufWdata, w_bufRdata;

  assign w_hostWr = !CE && !WE;
  assign w_start  = w_hostWr && r_rnb && (ADDRESS == REG_CMD) &&
                    (DATA[3:0] == START_KEY) && isValidOp(DATA[7:4]);

  nand_page_buffer #(.PAGE_WORDS(PAGE_WORDS), .AW(AW)) u_buffer (
    .i_clk   (CLK),
    .i_we    (w_bufWe),
    .i_addr  (w_bufAddr),
    .i_wdata (w_bufWdata),
    .o_rdata (w_bufRdata)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE:    if (w_start) w_nextState = S_CMD1;
      S_CMD1:
        if (r_phase) begin
          if (r_op == OP_RESET)       w_nextState = S_BUSY;
          else if (r_op == OP_STATUS) w_nextState = S_DATA_RD;
          else                        w_nextState = S_ADDR;
        end
      S_ADDR:
        if (r_phase && r_addrIdx == 3'd4)
          w_nextState = (r_op == OP_PROGRAM) ? S_DATA_WR : S_CMD2;
      S_DATA_WR: if (r_phase && r_wordCnt == LAST_WORD) w_nextState = S_CMD2;
      S_CMD2:    if (r_phase) w_nextState = S_BUSY;
      S_BUSY:
        if (r_waitCnt == 2'd3 && r_rnbSync)
          w_nextState = (r_op == OP_READ) ? S_DATA_RD : S_IDLE;
      S_DATA_RD:
        if (r_phase && (r_op == OP_STATUS || r_wordCnt == LAST_WORD))
          w_nextState = S_IDLE;
      default:   w_nextState = S_IDLE;
    endcase
  end

  // Every NAND bus cycle is two clocks; r_phase selects strobe-low vs strobe-high.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_phase   <= 1'b0;
      r_addrIdx <= '0;
      r_wordCnt <= '0;
      r_waitCnt <= '0;
      r_op      <= '0;
      r_rnb     <= 1'b1;
      r_status  <= '0;
    end else begin
      r_phase   <= (r_state != S_IDLE && r_state != S_BUSY) ? ~r_phase : 1'b0;
      r_waitCnt <= (r_state == S_BUSY && r_waitCnt != 2'd3) ? r_waitCnt + 2'd1 :
                   (r_state == S_BUSY) ? r_waitCnt : 2'd0;
      if (w_start) begin
        r_op      <= DATA[7:4];
        r_addrIdx <= (DATA[7:4] == OP_ERASE) ? 3'd2 : 3'd0;
        r_wordCnt <= '0;
        r_rnb     <= 1'b0;
      end else if (r_state == S_IDLE) begin
        r_rnb <= 1'b1;
      end
      if (r_state == S_ADDR && r_phase) r_addrIdx <= r_addrIdx + 3'd1;
      if ((r_state == S_DATA_WR || r_state == S_DATA_RD) && r_phase)
        r_wordCnt <= r_wordCnt + 1'b1;
      if (r_state == S_DATA_RD && r_phase && r_op == OP_STATUS)
        r_status <= r_dataIn[7:0];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_col1    <= '0;
      r_col2    <= '0;
      r_row1    <= '0;
      r_row2    <= '0;
      r_row3    <= '0;
      r_cmd     <= '0;
      r_rdAddr  <= '0;
      r_rnbMeta <= 1'b0;
      r_rnbSync <= 1'b0;
      r_dataIn  <= '0;
    end else begin
      r_rdAddr  <= ADDRESS;
      r_rnbMeta <= RnB_n;
      r_rnbSync <= r_rnbMeta;
      r_dataIn  <= data_n;
      if (w_hostWr && r_rnb) begin
        case (ADDRESS)
          REG_COL1: r_col1 <= DATA[7:0];
          REG_COL2: r_col2 <= DATA[7:0];
          REG_ROW1: r_row1 <= DATA[7:0];
          REG_ROW2: r_row2 <= DATA[7:0];
          REG_ROW3: r_row3 <= DATA[7:0];
          REG_CMD:  r_cmd  <= DATA;
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    case (r_addrIdx)
      3'd0:    w_addrByte = r_col1;
      3'd1:    w_addrByte = r_col2;
      3'd2:    w_addrByte = r_row1;
      3'd3:    w_addrByte = r_row2;
      default: w_addrByte = r_row3;
    endcase
  end

  // While programming, the buffer address runs one word ahead during the strobe-high
  // clock so the synchronous RAM output is ready when the next WE_n low begins.
  always_comb begin
    CE_n        = (r_state == S_IDLE);
    WE_n        = 1'b1;
    RE_n        = 1'b1;
    CLE_n       = 1'b0;
    ALE_n       = 1'b0;
    w_nandDrive = 1'b0;
    w_nandOut   = '0;
    unique case (r_state)
      S_CMD1: begin
        CLE_n = 1'b1; WE_n = r_phase; w_nandDrive = 1'b1;
        w_nandOut = {8'h00, firstCmd(r_op)};
      end
      S_ADDR: begin
        ALE_n = 1'b1; WE_n = r_phase; w_nandDrive = 1'b1;
        w_nandOut = {8'h00, w_addrByte};
      end
      S_DATA_WR: begin
        WE_n = r_phase; w_nandDrive = 1'b1; w_nandOut = w_bufRdata;
      end
      S_CMD2: begin
        CLE_n = 1'b1; WE_n = r_phase; w_nandDrive = 1'b1;
        w_nandOut = {8'h00, secondCmd(r_op)};
      end
      S_DATA_RD: RE_n = r_phase;
      default: ;
    endcase
    if (r_rnb) begin
      w_bufAddr  = ADDRESS[AW-1:0];
      w_bufWe    = w_hostWr && (ADDRESS < PAGE_LIMIT);
      w_bufWdata = DATA;
    end else begin
      w_bufAddr  = (r_state == S_DATA_WR && r_phase) ? r_wordCnt + 1'b1 : r_wordCnt;
      w_bufWe    = (r_state == S_DATA_RD) && r_phase && (r_op == OP_READ);
      w_bufWdata = r_dataIn;
    end
  end

  always_comb begin
    w_hostRdData = '0;
    if (r_rdAddr < PAGE_LIMIT) begin
      w_hostRdData = w_bufRdata;
    end else begin
      case (r_rdAddr)
        REG_COL1:   w_hostRdData = {8'h00, r_col1};
        REG_COL2:   w_hostRdData = {8'h00, r_col2};
        REG_ROW1:   w_hostRdData = {8'h00, r_row1};
        REG_ROW2:   w_hostRdData = {8'h00, r_row2};
        REG_ROW3:   w_hostRdData = {8'h00, r_row3};
        REG_CMD:    w_hostRdData = r_cmd;
        REG_STATUS: w_hostRdData = {r_status, 7'h00, r_rnb};
        default:    w_hostRdData = '0;
      endcase
    end
  end

  assign RnB    = r_rnb;
  assign DATA   = (!CE && WE && !OE) ? w_hostRdData : 16'hzzzz;
  assign data_n = w_nandDrive ? w_nandOut : 16'hzzzz;

endmodule

// File: tb/tb_nand_flash_controller.sv
// Directed bench for nand_flash_controller with a small behavioural NAND model
// that logs every write cycle and answers reads and busy periods.
module tb_nand_flash_controller;

  localparam int PW = 32;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CE, WE, OE;
  logic [11:0] ADDRESS;
  wire  [15:0] DATA;
  wire  [15:0] data_n;
  logic        RnB, CE_n, WE_n, RE_n, CLE_n, ALE_n;
  wire         RnB_n;

  logic [15:0] hostData;
  logic        hostDrive;
  logic [17:0] nandLog[$];
  int          rnbLowCnt;
  int          busyLen;
  logic        statusMode;
  logic [15:0] rdIdx;
  int          checkCount;
  int          errorCount;

  assign DATA   = hostDrive ? hostData : 16'hzzzz;
  assign data_n = (RE_n === 1'b0) ? (statusMode ? 16'h00C0 : ~rdIdx) : 16'hzzzz;
  assign RnB_n  = (rnbLowCnt == 0);

  always #5 CLK = ~CLK;

  nand_flash_controller #(.PAGE_WORDS(PW)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .CE      (CE),
    .WE      (WE),
    .OE      (OE),
    .ADDRESS (ADDRESS),
    .DATA    (DATA),
    .RnB     (RnB),
    .CE_n    (CE_n),
    .WE_n    (WE_n),
    .RE_n    (RE_n),
    .CLE_n   (CLE_n),
    .ALE_n   (ALE_n),
    .data_n  (data_n),
    .RnB_n   (RnB_n)
  );

  // NAND model: one log entry per write cycle, busy after confirm/reset commands.
  always @(negedge CLK) begin
    if (rnbLowCnt > 0) rnbLowCnt = rnbLowCnt - 1;
    if (!RESET && WE_n === 1'b0) begin
      nandLog.push_back({CLE_n, ALE_n, data_n});
      if (CLE_n) begin
        case (data_n[7:0])
          8'hFF, 8'hD0, 8'h10, 8'h30: rnbLowCnt = busyLen;
          8'h00: begin statusMode = 1'b0; rdIdx = 16'h0000; end
          8'h70: statusMode = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always @(posedge RE_n) rdIdx = rdIdx + 16'h0001;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic hostWrite(input logic [11:0] addr, input logic [15:0] value);
    @(negedge CLK);
    CE = 1'b0; WE = 1'b0; OE = 1'b1; ADDRESS = addr; hostData = value; hostDrive = 1'b1;
    @(posedge CLK);
    #1;
    CE = 1'b1; WE = 1'b1; hostDrive = 1'b0;
  endtask

  task automatic hostRead(input logic [11:0] addr, output logic [15:0] value);
    @(negedge CLK);
    CE = 1'b0; WE = 1'b1; OE = 1'b0; ADDRESS = addr;
    @(posedge CLK);
    #1;
    value = DATA;
    CE = 1'b1; OE = 1'b1;
  endtask

  // Waits for RnB; reports how many clocks RnB_n had been high before RnB rose.
  task automatic waitReady(input string tag, input int maxCycles, output int hiCycles);
    bit done = 0;
    hiCycles = 0;
    for (int c = 0; c < maxCycles && !done; c++) begin
      @(posedge CLK);
      if (RnB_n) hiCycles++;
      else       hiCycles = 0;
      #1;
      if (RnB) done = 1;
    end
    if (!done) checkOutput({tag, " ready timeout"}, 32'd0, 32'd1);
  endtask

  task automatic applyStimulus;
    logic [15:0] rd;
    int          hi;

    // Reset values
    RESET = 1'b1; CE = 1'b1; WE = 1'b1; OE = 1'b1; ADDRESS = '0;
    hostData = '0; hostDrive = 1'b0; rnbLowCnt = 0; busyLen = 4;
    statusMode = 1'b0; rdIdx = '0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset pins", {26'd0, CE_n, WE_n, RE_n, CLE_n, ALE_n, RnB},
                {26'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    checkOutput("reset data_n", {16'd0, data_n}, {16'd0, 16'hzzzz});
    checkOutput("reset DATA", {16'd0, DATA}, {16'd0, 16'hzzzz});
    @(negedge CLK) RESET = 1'b0;
    hostRead(12'hFFB, rd);
    checkOutput("status after reset", {16'd0, rd}, 32'h0000_0001);
    hostRead(12'hFFA, rd);
    checkOutput("cmd reg after reset", {16'd0, rd}, 32'h0);

    // NAND reset operation
    nandLog.delete(); busyLen = 6;
    hostWrite(12'hFFA, 16'hFFFF);
    checkOutput("reset op RnB low", {31'd0, RnB}, 32'd0);
    waitReady("reset op", 200, hi);
    checkOutput("reset op rnb delay", {31'd0, hi >= 4}, 32'd1);
    checkOutput("reset op cycles", nandLog.size(), 32'd1);
    checkOutput("reset op cmd", {14'd0, nandLog[0]}, {14'd0, 2'b10, 16'h00FF});

    // Erase with busy lockout
    hostWrite(12'hFF2, 16'h0060);
    hostWrite(12'hFF3, 16'h0070);
    hostWrite(12'hFF4, 16'h0080);
    nandLog.delete(); busyLen = 2;
    hostWrite(12'hFFA, 16'hFF6F);
    hostWrite(12'hFFA, 16'hFF7F);
    hostWrite(12'hFF2, 16'h0055);
    waitReady("erase", 200, hi);
    checkOutput("erase rnb delay", {31'd0, hi >= 4}, 32'd1);
    checkOutput("erase cycles", nandLog.size(), 32'd5);
    checkOutput("erase cmd1", {14'd0, nandLog[0]}, {14'd0, 2'b10, 16'h0060});
    checkOutput("erase row1", {14'd0, nandLog[1]}, {14'd0, 2'b01, 16'h0060});
    checkOutput("erase row2", {14'd0, nandLog[2]}, {14'd0, 2'b01, 16'h0070});
    checkOutput("erase row3", {14'd0, nandLog[3]}, {14'd0, 2'b01, 16'h0080});
    checkOutput("erase cmd2", {14'd0, nandLog[4]}, {14'd0, 2'b10, 16'h00D0});
    hostRead(12'hFFA, rd);
    checkOutput("lockout cmd reg", {16'd0, rd}, 32'h0000_FF6F);
    hostRead(12'hFF2, rd);
    checkOutput("lockout row1", {16'd0, rd}, 32'h0000_0060);

    // Program
    hostWrite(12'hFF0, 16'h0070);
    hostWrite(12'hFF1, 16'h0080);
    hostWrite(12'hFF2, 16'h000A);
    hostWrite(12'hFF3, 16'h000B);
    hostWrite(12'hFF4, 16'h000C);
    for (int i = 0; i < PW; i++) hostWrite(12'(i), 16'(i));
    nandLog.delete(); busyLen = 5;
    hostWrite(12'hFFA, 16'hFF8F);
    waitReady("program", 2000, hi);
    checkOutput("program cycles", nandLog.size(), 32'(PW + 7));
    checkOutput("program cmd1", {14'd0, nandLog[0]}, {14'd0, 2'b10, 16'h0080});
    checkOutput("program col1", {14'd0, nandLog[1]}, {14'd0, 2'b01, 16'h0070});
    checkOutput("program col2", {14'd0, nandLog[2]}, {14'd0, 2'b01, 16'h0080});
    checkOutput("program row1", {14'd0, nandLog[3]}, {14'd0, 2'b01, 16'h000A});
    checkOutput("program row2", {14'd0, nandLog[4]}, {14'd0, 2'b01, 16'h000B});
    checkOutput("program row3", {14'd0, nandLog[5]}, {14'd0, 2'b01, 16'h000C});
    for (int i = 0; i < PW; i++)
      checkOutput($sformatf("program word %0d", i), {14'd0, nandLog[6 + i]},
                  {14'd0, 2'b00, 16'(i)});
    checkOutput("program cmd2", {14'd0, nandLog[PW + 6]}, {14'd0, 2'b10, 16'h0010});

    // Page read, model returns ~index
    nandLog.delete(); busyLen = 3;
    hostWrite(12'hFFA, 16'hFF0F);
    waitReady("read", 2000, hi);
    checkOutput("read cycles", nandLog.size(), 32'd7);
    checkOutput("read cmd1", {14'd0, nandLog[0]}, {14'd0, 2'b10, 16'h0000});
    checkOutput("read row3", {14'd0, nandLog[5]}, {14'd0, 2'b01, 16'h000C});
    checkOutput("read cmd2", {14'd0, nandLog[6]}, {14'd0, 2'b10, 16'h0030});
    hostRead(12'd5, rd);
    checkOutput("read buf[5]", {16'd0, rd}, 32'h0000_FFFA);
    hostRead(12'd0, rd);
    checkOutput("read buf[0]", {16'd0, rd}, 32'h0000_FFFF);
    hostRead(12'(PW - 1), rd);
    checkOutput("read buf[last]", {16'd0, rd}, {16'd0, ~16'(PW - 1)});

    // Status
    nandLog.delete();
    hostWrite(12'hFFA, 16'hFF7F);
    waitReady("status", 200, hi);
    checkOutput("status cycles", nandLog.size(), 32'd1);
    checkOutput("status cmd", {14'd0, nandLog[0]}, {14'd0, 2'b10, 16'h0070});
    hostRead(12'hFFB, rd);
    checkOutput("status reg", {16'd0, rd}, 32'h0000_C001);

    // Unknown op and non-start writes only update the register
    nandLog.delete();
    hostWrite(12'hFFA, 16'h005F);
    checkOutput("bad op RnB", {31'd0, RnB}, 32'd1);
    hostWrite(12'hFFA, 16'hFF8E);
    checkOutput("no key RnB", {31'd0, RnB}, 32'd1);
    hostRead(12'hFFA, rd);
    checkOutput("no key cmd reg", {16'd0, rd}, 32'h0000_FF8E);
    hostRead(12'hFF8, rd);
    checkOutput("unmapped read", {16'd0, rd}, 32'h0);
    repeat (3) @(posedge CLK);
    checkOutput("ignored ops cycles", nandLog.size(), 32'd0);

    // Asynchronous reset in the middle of a program
    hostWrite(12'hFFA, 16'hFF8F);
    repeat (20) @(posedge CLK);
    #2;
    checkOutput("mid program CE_n", {31'd0, CE_n}, 32'd0);
    RESET = 1'b1;
    #1;
    checkOutput("abort pins", {26'd0, CE_n, WE_n, RE_n, CLE_n, ALE_n, RnB},
                {26'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    checkOutput("abort data_n", {16'd0, data_n}, {16'd0, 16'hzzzz});
    repeat (2) @(posedge CLK);
    @(negedge CLK) RESET = 1'b0;
    hostRead(12'hFFA, rd);
    checkOutput("abort cmd reg", {16'd0, rd}, 32'h0);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
